// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter sharing one registered bus among several cores.
// Each owner drives its own source select; holds are capped at MAX_HOLD.
module shared_bus_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int NUM_SRC   = 17,
   parameter int DATA_W    = 16,
   parameter int SEL_W     = 5,
   parameter int MAX_HOLD  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [NUM_CORES*SEL_W-1:0]    sel,
   input  logic [NUM_SRC*DATA_W-1:0]     src_data,
   output logic [NUM_CORES-1:0]          grant,
   output logic [DATA_W-1:0]             bus_out,
   output logic                          bus_valid,
   output logic [$clog2(NUM_CORES)-1:0]  bus_owner,
   output logic                          forced_rel
);

   localparam int OW = $clog2(NUM_CORES);
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
   localparam logic [OW-1:0] LAST = OW'(NUM_CORES - 1);

   typedef enum logic {
      IDLE,
      OWN
   } state_t;

   state_t              state_q, state_d;
   logic [OW-1:0]       ptr_q, ptr_d;
   logic [OW-1:0]       own_q, own_d;
   logic [7:0]          hold_q, hold_d;
   logic [NUM_CORES-1:0] grant_d;
   logic                frel_d;
   logic                keep;
   logic [OW-1:0]       pick;
   logic                found;
   logic [OW-1:0]       own_nxt;
   logic [SEL_W-1:0]    own_sel;
   logic [DATA_W-1:0]   mux_val;

   // First requester at or after the pointer, wrapping modulo NUM_CORES
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_CORES) j = j - NUM_CORES;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = OW'(j);
         end
      end
   end

   always_comb begin
      own_sel = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (OW'(c) == own_q) own_sel = sel[c*SEL_W +: SEL_W];
      end
   end

   // Out-of-range selects fall through to zero
   always_comb begin
      mux_val = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (int'(own_sel) == k) mux_val = src_data[k*DATA_W +: DATA_W];
      end
   end

   assign own_nxt = (own_q == LAST) ? '0 : own_q + OW'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant;
      ptr_d   = ptr_q;
      own_d   = own_q;
      hold_d  = hold_q;
      frel_d  = 1'b0;
      keep    = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            if (found) begin
               state_d = OWN;
               own_d   = pick;
               grant_d = {{(NUM_CORES-1){1'b0}}, 1'b1} << pick;
               hold_d  = 8'd1;
            end
         end
         OWN: begin
            if (!req[own_q] || hold_q == HOLD_MAX) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = own_nxt;
               hold_d  = '0;
               frel_d  = req[own_q];
            end else begin
               keep   = 1'b1;
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         own_q      <= '0;
         hold_q     <= '0;
         grant      <= '0;
         forced_rel <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         own_q      <= own_d;
         hold_q     <= hold_d;
         grant      <= grant_d;
         forced_rel <= frel_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_out   <= '0;
         bus_valid <= 1'b0;
         bus_owner <= '0;
      end else if (keep) begin
         bus_out   <= mux_val;
         bus_valid <= 1'b1;
         bus_owner <= own_q;
      end else begin
         bus_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: reset, single owner,
// round robin, forced release, hold-limit drop, async reset.
module tb_shared_bus_arbiter;

   localparam int NC = 4;
   localparam int NS = 17;
   localparam int DW = 16;
   localparam int SW = 5;
   localparam int MH = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NC-1:0]   req;
   logic [NC*SW-1:0] sel;
   logic [NS*DW-1:0] src_data;
   logic [NC-1:0]   grant;
   logic [DW-1:0]   bus_out;
   logic            bus_valid;
   logic [1:0]      bus_owner;
   logic            forced_rel;

   int checks = 0;
   int errors = 0;

   shared_bus_arbiter #(
      .NUM_CORES(NC),
      .NUM_SRC  (NS),
      .DATA_W   (DW),
      .SEL_W    (SW),
      .MAX_HOLD (MH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .sel       (sel),
      .src_data  (src_data),
      .grant     (grant),
      .bus_out   (bus_out),
      .bus_valid (bus_valid),
      .bus_owner (bus_owner),
      .forced_rel(forced_rel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_sel(input int c, input logic [SW-1:0] v);
      sel[c*SW +: SW] = v;
   endtask

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   int order [4] = '{0, 1, 3, 0};

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      sel   = '0;
      for (int k = 0; k < NS; k++)
         src_data[k*DW +: DW] = 16'h00A0 + 16'(k);

      // 1: reset with all requests high
      cyc();
      cyc();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_valid", 32'(bus_valid), 32'h0);
      chk("rst_bus", 32'(bus_out), 32'h0);
      chk("rst_owner", 32'(bus_owner), 32'h0);
      chk("rst_frel", 32'(forced_rel), 32'h0);
      rst_n = 1'b1;
      cyc();
      chk("rst_first", 32'(grant), 32'h1);
      chk("rst_first_v", 32'(bus_valid), 32'h0);
      req = '0;
      cyc();
      chk("rst_rel", 32'(grant), 32'h0);
      chk("rst_rel_v", 32'(bus_valid), 32'h0);

      // 2: single requester, select and out-of-range select
      do_reset();
      req = 4'b0100;
      set_sel(2, 5'd5);
      cyc();
      chk("s_grant", 32'(grant), 32'h4);
      chk("s_valid0", 32'(bus_valid), 32'h0);
      cyc();
      chk("s_bus", 32'(bus_out), 32'h00A5);
      chk("s_valid", 32'(bus_valid), 32'h1);
      chk("s_owner", 32'(bus_owner), 32'h2);
      set_sel(2, 5'd20);
      set_sel(0, 5'd9);
      req[0] = 1'b1;
      cyc();
      chk("s_oor_bus", 32'(bus_out), 32'h0);
      chk("s_oor_valid", 32'(bus_valid), 32'h1);
      chk("s_nonown", 32'(grant), 32'h4);
      set_sel(2, 5'd3);
      cyc();
      chk("s_bus3", 32'(bus_out), 32'h00A3);
      req = 4'b0001;
      cyc();
      chk("s_rel_g", 32'(grant), 32'h0);
      chk("s_rel_v", 32'(bus_valid), 32'h0);
      chk("s_rel_hold", 32'(bus_out), 32'h00A3);
      cyc();
      chk("s_next", 32'(grant), 32'h1);

      // 3: round robin with 2-cycle holds
      do_reset();
      req = 4'b1011;
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("rr_grant", 32'(grant), 32'(1) << order[i]);
         cyc();
         chk("rr_hold", 32'(grant), 32'(1) << order[i]);
         req[order[i]] = 1'b0;
         cyc();
         chk("rr_gap", 32'(grant), 32'h0);
         req[order[i]] = 1'b1;
         cyc();
      end

      // 4: forced release with a competing requester
      do_reset();
      req = 4'b1010;
      for (int i = 0; i < MH; i++) begin
         cyc();
         chk("f_grant", 32'(grant), 32'h2);
         chk("f_nofrel", 32'(forced_rel), 32'h0);
      end
      cyc();
      chk("f_gap", 32'(grant), 32'h0);
      chk("f_frel", 32'(forced_rel), 32'h1);
      chk("f_gap_v", 32'(bus_valid), 32'h0);
      cyc();
      chk("f_next", 32'(grant), 32'h8);
      chk("f_frel_end", 32'(forced_rel), 32'h0);

      // 5: sole requester forced repeatedly
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         cyc();
         chk("solo_grant", 32'(grant), (c % 9 == 8) ? 32'h0 : 32'h1);
         chk("solo_frel", 32'(forced_rel), (c % 9 == 8) ? 32'h1 : 32'h0);
      end

      // request drops on the MAX_HOLD edge: normal release
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < MH; c++) cyc();
      chk("drop_own", 32'(grant), 32'h1);
      req = '0;
      cyc();
      chk("drop_g", 32'(grant), 32'h0);
      chk("drop_frel", 32'(forced_rel), 32'h0);

      // 6: async reset mid-grant
      do_reset();
      req = 4'b0010;
      set_sel(1, 5'd7);
      cyc();
      chk("ar_grant", 32'(grant), 32'h2);
      cyc();
      chk("ar_bus", 32'(bus_out), 32'h00A7);
      chk("ar_owner", 32'(bus_owner), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_g", 32'(grant), 32'h0);
      chk("ar_v", 32'(bus_valid), 32'h0);
      chk("ar_b", 32'(bus_out), 32'h0);
      req = 4'b0011;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("ar_ptr", 32'(grant), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
Parametrised successor to the single-master datapath bus mux. Several cores share one bus, and each requests it with its own source selector. A round-robin arbiter grants the bus to one core at a time. The bus output is registered and zero-extended, with a valid flag, owner ID and forced release after a bounded hold. Sits between the per-core control units and the shared register/memory sources.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
NUM_SRC, 17, number of bus sources
DATA_W, 16, bus width; every source slot is DATA_W wide, and narrower sources are zero-extended by the integrator
SEL_W, 5, per-core source-select width
MAX_HOLD, 8, maximum consecutive granted cycles before forced release (1..255)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_CORES  per-core bus request, level
sel  in  NUM_CORES*SEL_W  per-core source select; core i occupies bits [i*SEL_W +: SEL_W]
src_data  in  NUM_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W]
grant  out  NUM_CORES  one-hot grant, registered
bus_out  out  DATA_W  registered bus value
bus_valid  out  1  bus_out holds data for the current owner
bus_owner  out  clog2(NUM_CORES)  index of the core that bus_out belongs to
forced_rel  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, bus_out=0, bus_valid=0, bus_owner=0, forced_rel=0.
  - FSM=IDLE, round-robin pointer=0, hold counter=0.
- FSM states: IDLE, OWN.
- IDLE:
  - At an edge with any req high, pick the first requester at or after the pointer, scanning upward modulo NUM_CORES.
  - Set grant[w]=1 and go to OWN; hold counter=1.
  - If no req is high, stay in IDLE.
- OWN, owner w, at each edge:
  - If req[w]=0: release. Clear grant, pointer=w+1 mod NUM_CORES, go to IDLE, bus_valid=0.
  - Else if hold counter==MAX_HOLD: forced release. Clear grant, pointer=w+1, forced_rel=1 for one cycle, go to IDLE.
  - Otherwise stay in OWN and increment the hold counter.
- Grant gap: after any release, grant is all-zero for at least one cycle. The bus never goes directly from one owner to another.
- Datapath:
  - At every edge where grant[w] is already high and w stays owner, sample s=sel[w].
  - bus_out <= src_data slot s; bus_valid<=1; bus_owner<=w.
  - Latency: req rises before edge E0 → grant at E0 → first valid bus_out at E1.
  - Result: bus_out reflects sel/src_data sampled one cycle earlier.
- Out-of-range select: s>=NUM_SRC gives bus_out=0, with bus_valid still 1.
- Not owning: while in IDLE or on the release edge, bus_valid<=0 and bus_out holds its last value.
- Simultaneous requests: the round-robin order decides; the winner is the lowest index at or after the pointer.
- Owner request edge cases:
  - A request dropping on the same edge as MAX_HOLD counts as a normal release, so forced_rel=0.
  - A forcibly released core keeping req high is re-granted only after every other requester has been served once.
  - If it is the sole requester, it is re-granted after the one-cycle gap.
- Reset mid-grant: immediate return to reset values; no grant survives.
- Other inputs: req from non-owners has no effect on the current grant. sel of non-owners is ignored.

Test Plan:
1. Reset: hold rst_n=0 with req=4'b1111 → grant=0, bus_valid=0, bus_out=0. Release reset → core0 granted at first edge (pointer=0).
2. Single request:
   - Core2 raises req with sel=5 and source5=16'h00A5 → grant=4'b0100 after 1 edge.
   - One edge later: bus_out=16'h00A5, bus_valid=1, bus_owner=2.
   - Change sel to 20 → bus_out=0 next edge.
3. Round robin: req=4'b1011, each core releasing after 2 granted cycles → grant order 0,1,3,0, with a single all-zero grant cycle between each.
4. Forced release:
   - MAX_HOLD=8, core1 holds req continuously with core3 also requesting.
   - grant[1] high for exactly 8 cycles, then forced_rel pulses once.
   - Gap cycle, then grant=4'b1000.
5. Sole requester forced: only core0 requests for 20 cycles → grant pattern of 8 high, 1 low, repeating. forced_rel pulses at cycles 8 and 17.
6. Async reset mid-grant: assert rst_n=0 between edges while core1 owns → grant, bus_valid and bus_out clear without a clock edge. After reset, the pointer restarts at 0.
